// File: rtl/pl_sink_fifo.sv
// Terminal sink of a valid/stall pipeline: small FWFT FIFO with a registered
// stall towards upstream and a valid/ack port towards the consumer.
module pl_sink_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             stall_out,
  input  logic             flush,
  output logic             deq_valid,
  output logic [WIDTH-1:0] deq_data,
  input  logic             deq_ack,
  output logic [AW:0]      count,
  output logic             last_seen
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             stall_q, stall_d;
  logic             last_q, last_d;
  logic             push, pop;

  assign push      = valid_in && !stall_q;
  assign pop       = (cnt_q != '0) && deq_ack;
  assign deq_valid = (cnt_q != '0);
  assign deq_data  = mem_q[rd_q];
  assign count     = cnt_q;
  assign stall_out = stall_q;
  assign last_seen = last_q;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    last_d  = last_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
      stall_d = 1'b0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      // stall is precomputed from next occupancy, so full always implies stall
      stall_d = (cnt_d == (AW+1)'(DEPTH));
      if (pop && deq_data[WIDTH-1]) last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= data_in;
  end

endmodule
